uart_baud_gen_frac: RTL and testbench
=====================================

// Module: uart_baud_gen_frac
// PURPOSE
//  Parametrised UART baud generator with a fractional divisor. Emits an oversample
//  tick (OVS x baud) for the RX sampler and a bit tick (1 x baud) for the TX shifter.
//  Divisor updates are shadowed and applied only on tick boundaries. A resync input
//  realigns the phase to an RX start-bit edge. Sits between the CSR block and uart_tx/uart_rx.
// PARAMETERS
//  DVSR_W     16   width of the integer divisor (clk cycles per os_tick)
//  FRAC_W     4    width of the fractional divisor (units of 1/2**FRAC_W cycle)
//  OVS        16   os_ticks per bit_tick (>=2)
//  RST_INT    54   integer divisor loaded at reset (>=2)
//  RST_FRAC   0    fractional divisor loaded at reset
// PORTS
//  clk        in   1       system clock
//  reset      in   1       asynchronous, active-high reset
//  en         in   1       run enable; 0 freezes all counters, no ticks
//  dvsr_int   in   DVSR_W  requested integer divisor
//  dvsr_frac  in   FRAC_W  requested fractional divisor
//  dvsr_wr    in   1       1-cycle pulse: capture dvsr_int/dvsr_frac into pending
//  resync     in   1       1-cycle pulse: restart phase from zero
//  os_tick    out  1       1-cycle pulse, rate clk/(int+frac/2**FRAC_W)
//  bit_tick   out  1       1-cycle pulse, coincident with every OVS-th os_tick
//  upd_pend   out  1       pending divisor not yet applied
//  cfg_err    out  1       last dvsr_wr was rejected (dvsr_int<2)
// BEHAVIOUR
//  - One clock; reset asynchronous, active-high. On reset: os_tick=0, bit_tick=0,
//    upd_pend=0, cfg_err=0; active divisor={RST_INT,RST_FRAC}; cycle count, frac
//    accumulator (FRAC_W bits) and os counter (0..OVS-1) all 0.
//  - Period: cycle counter counts 0..P-1, P=int (+1 if this period's frac add carries).
//    At start of each period acc<=acc+frac; carry-out selects P=int+1. Mean period is
//    int+frac/2**FRAC_W; no drift beyond 1 cycle vs ideal.
//  - os_tick is registered: high in the cycle after count reaches P-1. With en held 1
//    from cycle 0 and frac=0, pulses at cycles int, 2*int, ...
//  - os counter increments on os_tick, wraps OVS-1 -> 0; bit_tick asserted with the
//    os_tick on which the counter wraps (first bit_tick = OVS-th os_tick).
//  - en=0: counters hold, outputs 0; resumes from held state, no extra tick.
//  - dvsr_wr with dvsr_int<2: rejected, cfg_err<=1, pending unchanged. Valid write:
//    cfg_err<=0, pending<=inputs, upd_pend<=1; later writes overwrite pending.
//  - Pending applied: at the cycle a period ends (count==P-1) while en=1, or next cycle
//    if en=0 or resync; upd_pend<=0 then. A period in progress always completes with
//    the old divisor. New period length uses new int and frac (acc not cleared).
//  - resync: next cycle count=0, acc=0, os counter=0; no tick that cycle even if
//    count was at P-1. resync+dvsr_wr same cycle: new divisor applies, phase cleared.
//  - Reset mid-operation: immediate return to reset state, pending write discarded.
//  - Counter widths DVSR_W+1 internally; no overflow for int=2**DVSR_W-1, frac max.
// TESTING
//  1 reset, en=1, wr int=4 frac=0 -> os_tick at cycles 4,8,12..; bit_tick every 64 cycles.
//  2 int=3 frac=8 (FRAC_W=4) -> periods alternate 3,4; 16 os_ticks in exactly 56 cycles.
//  3 int=10 running, wr int=5 at count=3 -> that period still 10 cycles, next ones 5;
//    upd_pend high from wr+1 to boundary.
//  4 wr int=1 -> cfg_err=1, period unchanged; then wr int=6 -> cfg_err=0, 6-cycle period.
//  5 resync at count=7 of int=10 -> no tick, next os_tick 10 cycles later, os count=0
//    (bit_tick after OVS further os_ticks); en=0 for 20 cycles -> no ticks, phase held.
//  6 assert reset mid-period with pending write -> all outputs 0 immediately, period=RST_INT.

Source files
------------

// File: rtl/uart_baud_gen_frac.sv
// uart_baud_gen_frac: fractional-divisor UART baud generator producing
// oversample and bit ticks, with shadowed divisor updates and phase resync.
module uart_baud_gen_frac #(
    parameter int DVSR_W   = 16,
    parameter int FRAC_W   = 4,
    parameter int OVS      = 16,
    parameter int RST_INT  = 54,
    parameter int RST_FRAC = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [DVSR_W-1:0] dvsr_int,
    input  logic [FRAC_W-1:0] dvsr_frac,
    input  logic              dvsr_wr,
    input  logic              resync,
    output logic              os_tick,
    output logic              bit_tick,
    output logic              upd_pend,
    output logic              cfg_err
);
    localparam int OW = $clog2(OVS);

    logic [DVSR_W-1:0] act_int, pend_int;
    logic [FRAC_W-1:0] act_frac, pend_frac, acc;
    logic [FRAC_W:0]   acc_sum;
    logic [DVSR_W:0]   cnt, last_cnt;
    logic [OW-1:0]     os_cnt;
    logic              cy, last, wr_ok, apply, os_wrap;

    // cy holds this period's carry; cnt is never 0 at the last cycle since int>=2
    always_comb begin
        last_cnt = {1'b0, act_int} - (DVSR_W+1)'(!cy);
        last     = cnt == last_cnt;
        wr_ok    = dvsr_wr && dvsr_int > DVSR_W'(1);
        apply    = (upd_pend || wr_ok) && (resync || (en ? last : cnt == '0));
        acc_sum  = {1'b0, acc} + {1'b0, act_frac};
        os_wrap  = os_cnt == OW'(OVS-1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            acc       <= '0;
            cy        <= 1'b0;
            os_cnt    <= '0;
            os_tick   <= 1'b0;
            bit_tick  <= 1'b0;
            upd_pend  <= 1'b0;
            cfg_err   <= 1'b0;
            act_int   <= DVSR_W'(RST_INT);
            act_frac  <= FRAC_W'(RST_FRAC);
            pend_int  <= '0;
            pend_frac <= '0;
        end else begin
            os_tick  <= en && last && !resync;
            bit_tick <= en && last && !resync && os_wrap;
            if (resync) begin
                cnt    <= '0;
                acc    <= '0;
                cy     <= 1'b0;
                os_cnt <= '0;
            end else if (en) begin
                cnt <= last ? '0 : cnt + (DVSR_W+1)'(1);
                if (cnt == '0)
                    {cy, acc} <= acc_sum;
                if (last)
                    os_cnt <= os_wrap ? '0 : os_cnt + OW'(1);
            end
            // a write coinciding with an apply point takes effect directly
            if (apply) begin
                act_int  <= wr_ok ? dvsr_int : pend_int;
                act_frac <= wr_ok ? dvsr_frac : pend_frac;
                upd_pend <= 1'b0;
            end else if (wr_ok) begin
                pend_int  <= dvsr_int;
                pend_frac <= dvsr_frac;
                upd_pend  <= 1'b1;
            end
            if (dvsr_wr)
                cfg_err <= !wr_ok;
        end
    end
endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// tb_uart_baud_gen_frac: directed and randomized checks of the baud generator
// against a cycle-level period/accumulator reference model.
module tb_uart_baud_gen_frac;
    localparam int DW = 16, FW = 4, OVS = 16, RI = 54, RF = 0;

    logic          clk = 1'b0;
    logic          reset, en, dvsr_wr, resync;
    logic [DW-1:0] dvsr_int;
    logic [FW-1:0] dvsr_frac;
    logic          os_tick, bit_tick, upd_pend, cfg_err;
    int            checks = 0, errors = 0;
    bit            chk_on = 0;

    uart_baud_gen_frac #(
        .DVSR_W(DW), .FRAC_W(FW), .OVS(OVS), .RST_INT(RI), .RST_FRAC(RF)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .dvsr_int(dvsr_int),
        .dvsr_frac(dvsr_frac), .dvsr_wr(dvsr_wr), .resync(resync),
        .os_tick(os_tick), .bit_tick(bit_tick), .upd_pend(upd_pend), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: each period lasts int cycles, plus one when the running
    // fractional sum overflows 2**FW at the period start.
    int m_t, m_len, m_fsum, m_os, m_int, m_frac, p_int, p_frac;
    bit m_pend, m_err, e_os, e_bit;

    always @(posedge clk or posedge reset) begin
        bit ok, applied, fin;
        if (reset) begin
            m_t = 0; m_len = RI; m_fsum = 0; m_os = 0; m_int = RI; m_frac = RF;
            p_int = 0; p_frac = 0; m_pend = 0; m_err = 0; e_os = 0; e_bit = 0;
        end else begin
            ok  = dvsr_wr && dvsr_int >= 2;
            fin = 0;
            if (!resync && en) begin
                if (m_t == 0) begin
                    m_len  = m_int + int'((m_fsum + m_frac) >= 2**FW);
                    m_fsum = (m_fsum + m_frac) % 2**FW;
                end
                fin = m_t == m_len - 1;
            end
            applied = (m_pend || ok) && (resync || (en ? fin : m_t == 0));
            e_os  = fin;
            e_bit = fin && m_os == OVS - 1;
            if (resync) begin
                m_t = 0; m_fsum = 0; m_os = 0;
            end else if (en) begin
                m_t = fin ? 0 : m_t + 1;
                if (fin) m_os = (m_os + 1) % OVS;
            end
            if (applied) begin
                m_int  = ok ? int'(dvsr_int) : p_int;
                m_frac = ok ? int'(dvsr_frac) : p_frac;
                m_pend = 0;
            end else if (ok) begin
                p_int = dvsr_int; p_frac = dvsr_frac; m_pend = 1;
            end
            if (dvsr_wr) m_err = !ok;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("os_tick", os_tick, e_os);
            check("bit_tick", bit_tick, e_bit);
            check("upd_pend", upd_pend, m_pend);
            check("cfg_err", cfg_err, m_err);
        end
    end

    task automatic wr(input int i, input int f, input bit rs);
        @(negedge clk);
        dvsr_wr = 1; dvsr_int = DW'(i); dvsr_frac = FW'(f); resync = rs;
        @(negedge clk);
        dvsr_wr = 0; resync = 0;
    endtask

    initial begin
        int n, k;
        reset = 0; en = 0; dvsr_wr = 0; resync = 0; dvsr_int = '0; dvsr_frac = '0;
        #1 reset = 1;
        #1;
        check("rst_os_tick", os_tick, 0);
        check("rst_bit_tick", bit_tick, 0);
        check("rst_upd_pend", upd_pend, 0);
        check("rst_cfg_err", cfg_err, 0);
        repeat (2) @(negedge clk);
        reset = 0; chk_on = 1; en = 1;

        wr(4, 0, 1);
        n = 0;
        repeat (128) begin @(negedge clk); n += int'(bit_tick); end
        check("bit_ticks_int4", n, 2);

        wr(3, 8, 1);
        n = 0; k = 0;
        repeat (56) begin @(negedge clk); n += int'(os_tick); k = int'(os_tick); end
        check("ticks_in_56", n, 16);
        check("tick_at_56", k, 1);

        wr(1, 0, 0);
        check("cfg_err_rej", cfg_err, 1);
        check("no_pend_rej", upd_pend, 0);
        wr(6, 0, 0);
        check("cfg_err_ok", cfg_err, 0);
        repeat (30) @(negedge clk);

        wr(10, 0, 1);
        repeat (7) @(negedge clk);
        wr(5, 0, 0);
        check("pend_after_wr", upd_pend, 1);
        repeat (40) @(negedge clk);

        en = 0; n = 0;
        repeat (20) begin @(negedge clk); n += int'(os_tick); end
        check("en_off_ticks", n, 0);
        en = 1;
        repeat (20) @(negedge clk);

        wr(12, 0, 1);
        repeat (3) @(negedge clk);
        wr(7, 0, 0);
        #2 reset = 1;
        #1;
        check("mid_rst_os", os_tick, 0);
        check("mid_rst_bit", bit_tick, 0);
        check("mid_rst_pend", upd_pend, 0);
        check("mid_rst_err", cfg_err, 0);
        @(negedge clk);
        reset = 0;
        k = 0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (os_tick) begin k = c; break; end
        end
        check("rst_period", k, RI);

        repeat (3000) begin
            @(negedge clk);
            en        = $urandom_range(9) != 0;
            dvsr_wr   = $urandom_range(39) == 0;
            dvsr_int  = DW'($urandom_range(12));
            dvsr_frac = FW'($urandom);
            resync    = $urandom_range(59) == 0;
        end
        @(negedge clk);
        dvsr_wr = 0; resync = 0;
        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
